io_bridge_uart: RTL and testbench

// - Byte-wide 8N1 UART slave on the 16-bit IO bridge bus of the HPS/FPGA system; sits directly downstream of the bridge master.
// - Bridge master drives address/enable/rw/write-data; this block returns read data, acknowledge and a level IRQ.
// - TX and RX FIFOs decouple HPS software from the serial line (e.g. Bluetooth/Wi-Fi module on GPIO).

---
 rtl/io_bridge_uart_if.sv | 22 ++
 rtl/io_bridge_uart.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_io_bridge_uart.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bridge_uart_if.sv
// IO bridge bus bundle between the HPS bridge master and a peripheral.
// The master drives the request fields; the peripheral returns data, ack and irq.
interface io_bridge_uart_if;
    logic [15:0] io_address;
    logic        io_bus_enable;
    logic [1:0]  io_byte_enable;
    logic        io_rw;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;

    modport master (
        output io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
        input  io_read_data, io_acknowledge, io_irq
    );

    modport slave (
        input  io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
        output io_read_data, io_acknowledge, io_irq
    );
endinterface

// File: rtl/io_bridge_uart.sv
// Byte-wide 8N1 UART on the 16-bit IO bridge bus, with TX/RX FIFOs,
// a programmable 16x tick generator and a level interrupt.

// Synchronous FIFO with first-word fall-through read (head visible while not empty).
module io_bridge_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_rdata   = r_mem[r_rd_ptr];
    // A pop from empty is ignored; a push while full succeeds only if a pop frees the slot.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module io_bridge_uart #(
    parameter logic [15:0] BASE_ADDR   = 16'h0200,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
    input  logic             clk,
    input  logic             reset_n,
    io_bridge_uart_if.slave  bus,
    input  logic             uart_rxd,
    output logic             uart_txd
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ---------------- bus side ----------------
    logic        r_busy;
    logic        r_ack;
    logic [1:0]  r_ctrl;
    logic [15:0] r_div;
    logic        r_overrun;
    logic        r_frame_err;
    logic        r_irq;

    logic        w_hit;
    logic        w_start;
    logic [1:0]  w_sel;
    logic        w_tx_push;
    logic        w_rx_pop;
    logic        w_stat_clr;
    logic        w_ctrl_wr;
    logic        w_div_wr;
    logic [15:0] w_div_new;
    logic [15:0] w_rd_mux;
    logic        w_unused;

    // FIFO wires
    logic [7:0]  w_tx_q;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_tx_pop;
    logic [7:0]  w_rx_q;
    logic        w_rx_empty;
    logic        w_rx_full;
    logic        w_rx_push;
    logic        w_tx_idle;

    // Tick generator
    logic [15:0] r_tick_cnt;
    logic        w_tick;

    // TX FSM
    uart_state_t r_tx_state, w_tx_state_next;
    logic [3:0]  r_tx_cnt, w_tx_cnt_next;
    logic [2:0]  r_tx_bit, w_tx_bit_next;
    logic [7:0]  r_tx_shift, w_tx_shift_next;
    logic        r_txd, w_txd_next;

    // RX FSM
    logic        r_rx_sync1;
    logic        r_rx_sync2;
    logic        r_rx_prev;
    uart_state_t r_rx_state, w_rx_state_next;
    logic [3:0]  r_rx_cnt, w_rx_cnt_next;
    logic [2:0]  r_rx_bit, w_rx_bit_next;
    logic [7:0]  r_rx_shift, w_rx_shift_next;
    logic        w_rx_ovr_set;
    logic        w_rx_fe_set;

    assign w_unused  = &{1'b0, bus.io_address[0]};

    // The master holds its request fields through the ack cycle, so all side
    // effects are keyed off r_ack and use the still-valid request inputs.
    assign w_hit      = (bus.io_address[15:3] == BASE_ADDR[15:3]);
    assign w_start    = bus.io_bus_enable & w_hit & ~r_busy;
    assign w_sel      = bus.io_address[2:1];
    assign w_tx_push  = r_ack & ~bus.io_rw & (w_sel == 2'd0) & bus.io_byte_enable[0];
    assign w_rx_pop   = r_ack &  bus.io_rw & (w_sel == 2'd0);
    assign w_stat_clr = r_ack &  bus.io_rw & (w_sel == 2'd1);
    assign w_ctrl_wr  = r_ack & ~bus.io_rw & (w_sel == 2'd2) & bus.io_byte_enable[0];
    assign w_div_wr   = r_ack & ~bus.io_rw & (w_sel == 2'd3) & (|bus.io_byte_enable);
    assign w_div_new  = {bus.io_byte_enable[1] ? bus.io_write_data[15:8] : r_div[15:8],
                         bus.io_byte_enable[0] ? bus.io_write_data[7:0]  : r_div[7:0]};

    assign w_tx_idle  = w_tx_empty & (r_tx_state == ST_IDLE);

    // Handshake: one ack per enable assertion; busy blocks re-acks until enable drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= w_start;
            if (!bus.io_bus_enable) begin
                r_busy <= 1'b0;
            end else if (w_start) begin
                r_busy <= 1'b1;
            end
        end
    end

    // Control/divisor registers, sticky error flags (a new error beats a clear) and irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl      <= 2'b00;
            r_div       <= DEFAULT_DIV;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= bus.io_write_data[1:0];
            end
            if (w_div_wr) begin
                r_div <= w_div_new;
            end
            r_overrun   <= w_rx_ovr_set | (r_overrun & ~w_stat_clr);
            r_frame_err <= w_rx_fe_set  | (r_frame_err & ~w_stat_clr);
            r_irq       <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
        end
    end

    // Read data mux; driven only during the ack cycle.
    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_sel)
            2'd0:    w_rd_mux = w_rx_empty ? 16'h0000 : {8'h00, w_rx_q};
            2'd1:    w_rd_mux = {11'd0, r_frame_err, r_overrun, w_tx_idle, ~w_tx_full, ~w_rx_empty};
            2'd2:    w_rd_mux = {14'd0, r_ctrl};
            default: w_rd_mux = r_div;
        endcase
    end

    assign bus.io_read_data   = r_ack ? w_rd_mux : 16'h0000;
    assign bus.io_acknowledge = r_ack;
    assign bus.io_irq         = r_irq;
    assign uart_txd           = r_txd;

    // 16x tick: down-counter reloads from DIVISOR; a DIVISOR write restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= DEFAULT_DIV;
        end else if (w_div_wr) begin
            r_tick_cnt <= w_div_new;
        end else if (w_tick) begin
            r_tick_cnt <= r_div;
        end else begin
            r_tick_cnt <= r_tick_cnt - 16'd1;
        end
    end
    assign w_tick = (r_tick_cnt == 16'd0);

    io_bridge_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_tx_push),
        .i_wdata (bus.io_write_data[7:0]),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_q),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    io_bridge_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_rx_push),
        .i_wdata (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_q),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    // TX state register; txd is registered from the next-state decode so it is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_txd      <= w_txd_next;
        end
    end

    // TX next-state: 16 ticks per bit; STOP chains straight into START when more data waits.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                if (w_tick && !w_tx_empty) begin
                    w_tx_state_next = ST_START;
                    w_tx_cnt_next   = 4'd0;
                    w_tx_shift_next = w_tx_q;
                    w_tx_pop        = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_state_next = ST_DATA;
                        w_tx_cnt_next   = 4'd0;
                        w_tx_bit_next   = 3'd0;
                    end else begin
                        w_tx_cnt_next = r_tx_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_next   = 4'd0;
                        w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                        if (r_tx_bit == 3'd7) begin
                            w_tx_state_next = ST_STOP;
                        end else begin
                            w_tx_bit_next = r_tx_bit + 3'd1;
                        end
                    end else begin
                        w_tx_cnt_next = r_tx_cnt + 4'd1;
                    end
                end
            end
            default: begin
                if (w_tick) begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_next = 4'd0;
                        if (!w_tx_empty) begin
                            w_tx_state_next = ST_START;
                            w_tx_shift_next = w_tx_q;
                            w_tx_pop        = 1'b1;
                        end else begin
                            w_tx_state_next = ST_IDLE;
                        end
                    end else begin
                        w_tx_cnt_next = r_tx_cnt + 4'd1;
                    end
                end
            end
        endcase
        case (w_tx_state_next)
            ST_START: w_txd_next = 1'b0;
            ST_DATA:  w_txd_next = w_tx_shift_next[0];
            default:  w_txd_next = 1'b1;
        endcase
    end

    // RX synchroniser, edge-detect history and FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_sync1 <= uart_rxd;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    // RX next-state: confirm start at mid-bit, then sample every 16 ticks; judge the stop bit.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_push       = 1'b0;
        w_rx_ovr_set    = 1'b0;
        w_rx_fe_set     = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_sync2) begin
                    w_rx_state_next = ST_START;
                    w_rx_cnt_next   = 4'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_rx_cnt == 4'd7) begin
                        w_rx_cnt_next = 4'd0;
                        w_rx_bit_next = 3'd0;
                        w_rx_state_next = r_rx_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        w_rx_cnt_next = r_rx_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_cnt_next   = 4'd0;
                        w_rx_shift_next = {r_rx_sync2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            w_rx_state_next = ST_STOP;
                        end else begin
                            w_rx_bit_next = r_rx_bit + 3'd1;
                        end
                    end else begin
                        w_rx_cnt_next = r_rx_cnt + 4'd1;
                    end
                end
            end
            default: begin
                if (w_tick) begin
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_cnt_next   = 4'd0;
                        w_rx_state_next = ST_IDLE;
                        if (!r_rx_sync2) begin
                            w_rx_fe_set = 1'b1;
                        end else if (w_rx_full) begin
                            w_rx_ovr_set = 1'b1;
                        end else begin
                            w_rx_push = 1'b1;
                        end
                    end else begin
                        w_rx_cnt_next = r_rx_cnt + 4'd1;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_io_bridge_uart.sv
// Directed bench for io_bridge_uart: a queue-based model of the serial line
// and RX FIFO plus literal expectations for key register reads.
module tb_io_bridge_uart;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic uart_rxd;
    logic uart_txd;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;

    io_bridge_uart_if bus_if ();

    io_bridge_uart #(
        .BASE_ADDR   (16'h0200),
        .FIFO_DEPTH  (16),
        .DEFAULT_DIV (16'd26)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;
    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0]  rx_q[$];
    int          stream[$];      // expected txd per cycle: 0/1, 2 = don't care
    logic        tx_track = 1'b0;
    logic [15:0] m_div = 16'd26;
    logic        m_ovr = 1'b0;
    logic        m_fe  = 1'b0;
    logic        m_rx_ie = 1'b0;
    logic        m_tx_ie = 1'b0;
    logic [15:0] exp_rd;
    logic        exp_rd_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: read data during/outside ack, and the serial waveform.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_if.io_acknowledge) begin
                if (exp_rd_valid) begin
                    chk("rdata", {16'h0, bus_if.io_read_data}, {16'h0, exp_rd});
                    exp_rd_valid = 1'b0;
                end
            end else begin
                chk("rdata_idle", {16'h0, bus_if.io_read_data}, 32'h0);
            end
            if (tx_track) begin
                if (stream.size() > 0) begin
                    int e;
                    e = stream.pop_front();
                    if (e != 2) chk("txd", {31'h0, uart_txd}, e);
                end else begin
                    chk("txd_idle", {31'h0, uart_txd}, 32'h1);
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 16; i++) stream.push_back(0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 16; i++) stream.push_back(int'(b[k]));
        for (int i = 0; i < 16; i++) stream.push_back(1);
    endtask

    task automatic bus_xfer(input logic rw, input logic [1:0] sel, input logic [1:0] be,
                            input logic [15:0] wd, input logic [15:0] exp);
        int lat;
        logic [15:0] seen;
        lat = 0;
        seen = 16'h0;
        @(posedge clk); #1;
        if (rw) begin
            exp_rd = exp;
            exp_rd_valid = 1'b1;
        end
        bus_if.io_address     = 16'h0200 + {13'd0, sel, 1'b0};
        bus_if.io_rw          = rw;
        bus_if.io_byte_enable = be;
        bus_if.io_write_data  = wd;
        bus_if.io_bus_enable  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus_if.io_acknowledge) begin
                lat = i;
                seen = bus_if.io_read_data;
                break;
            end
        end
        chk("ack_latency", lat, 1);
        if (lat != 0) begin
            @(posedge clk); #1;
        end
        bus_if.io_bus_enable = 1'b0;
        exp_rd_valid = 1'b0;
        $display("bus %s reg=%0d be=%b wdata=%h rdata=%h", rw ? "rd" : "wr", sel, be, wd, seen);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] be, input logic [15:0] wd);
        bus_xfer(1'b0, sel, be, wd, 16'h0);
        case (sel)
            2'd0: if (be[0]) begin
                if (tx_track && m_div == 16'd0) begin
                    if (stream.size() == 0) stream.push_back(2);
                    push_frame(wd[7:0]);
                end
                if (loop_en) begin
                    if (rx_q.size() < 16) rx_q.push_back(wd[7:0]);
                    else m_ovr = 1'b1;
                end
            end
            2'd2: if (be[0]) begin
                m_rx_ie = wd[0];
                m_tx_ie = wd[1];
            end
            2'd3: begin
                if (be[0]) m_div[7:0]  = wd[7:0];
                if (be[1]) m_div[15:8] = wd[15:8];
            end
            default: ;
        endcase
    endtask

    task automatic rd_data();
        logic [15:0] e;
        e = (rx_q.size() > 0) ? {8'h00, rx_q[0]} : 16'h0000;
        bus_xfer(1'b1, 2'd0, 2'b11, 16'h0, e);
        if (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    // Status reads are only issued with the transmitter idle.
    task automatic rd_status();
        logic [15:0] e;
        e = {11'd0, m_fe, m_ovr, 1'b1, 1'b1, rx_q.size() != 0};
        bus_xfer(1'b1, 2'd1, 2'b11, 16'h0, e);
        m_fe = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rxd_drv = 1'b0;
        repeat (16) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 rxd_drv = b[k];
            repeat (16) @(posedge clk);
        end
        #1 rxd_drv = stop;
        repeat (16) @(posedge clk);
        #1 rxd_drv = 1'b1;
        repeat (4) @(posedge clk);
        if (stop) begin
            if (rx_q.size() < 16) rx_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic wait_tx_done();
        for (int i = 0; i < 4000 && stream.size() != 0; i++) @(posedge clk);
        chk("tx_drain", {31'h0, stream.size() == 0}, 32'h1);
        repeat (30) @(posedge clk);
    endtask

    function automatic logic model_irq();
        return (m_rx_ie && rx_q.size() != 0) || m_tx_ie;
    endfunction

    initial begin
        bus_if.io_address = 16'h0;
        bus_if.io_bus_enable = 1'b0;
        bus_if.io_byte_enable = 2'b00;
        bus_if.io_rw = 1'b0;
        bus_if.io_write_data = 16'h0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_txd", {31'h0, uart_txd}, 32'h1);
        chk("reset_irq", {31'h0, bus_if.io_irq}, 32'h0);
        chk("reset_ack", {31'h0, bus_if.io_acknowledge}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Reset values
        bus_xfer(1'b1, 2'd1, 2'b11, 16'h0, 16'h0006);
        chk("irq_after_reset", {31'h0, bus_if.io_irq}, 32'h0);
        bus_xfer(1'b1, 2'd3, 2'b11, 16'h0, 16'h001A);
        bus_xfer(1'b1, 2'd2, 2'b11, 16'h0, 16'h0000);

        // Undecoded address never acknowledged
        begin
            logic saw;
            saw = 1'b0;
            @(posedge clk); #1;
            bus_if.io_address = 16'h0100;
            bus_if.io_rw = 1'b1;
            bus_if.io_bus_enable = 1'b1;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus_if.io_acknowledge) saw = 1'b1;
            end
            bus_if.io_bus_enable = 1'b0;
            chk("undecoded_noack", {31'h0, saw}, 32'h0);
        end

        // Fastest tick; byte-lane write of DIVISOR
        wr(2'd3, 2'b01, 16'hFF00);
        bus_xfer(1'b1, 2'd3, 2'b11, 16'h0, 16'h0000);
        wr(2'd3, 2'b10, 16'h12FF);
        bus_xfer(1'b1, 2'd3, 2'b11, 16'h0, m_div);
        wr(2'd3, 2'b11, 16'h0000);
        tx_track = 1'b1;

        // Single TX frame
        wr(2'd0, 2'b01, 16'h00A5);
        wait_tx_done();
        rd_status();

        // Loopback, back-to-back frames
        loop_en = 1'b1;
        wr(2'd0, 2'b01, 16'h0055);
        wr(2'd0, 2'b01, 16'h003C);
        wait_tx_done();
        bus_xfer(1'b1, 2'd0, 2'b11, 16'h0, 16'h0055);
        void'(rx_q.pop_front());
        bus_xfer(1'b1, 2'd0, 2'b11, 16'h0, 16'h003C);
        void'(rx_q.pop_front());
        bus_xfer(1'b1, 2'd0, 2'b11, 16'h0, 16'h0000);
        rd_status();
        loop_en = 1'b0;

        // Overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
        repeat (10) @(posedge clk);
        bus_xfer(1'b1, 2'd1, 2'b11, 16'h0, 16'h000F);
        m_ovr = 1'b0;
        for (int i = 0; i < 16; i++) rd_data();
        rd_status();

        // Framing error
        send_frame(8'hC3, 1'b0);
        repeat (30) @(posedge clk);
        bus_xfer(1'b1, 2'd1, 2'b11, 16'h0, 16'h0016);
        m_fe = 1'b0;
        rd_status();

        // Short glitch with a 2-clock tick
        wr(2'd3, 2'b11, 16'h0001);
        @(posedge clk); #1 rxd_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd_drv = 1'b1;
        repeat (100) @(posedge clk);
        rd_status();
        rd_data();
        wr(2'd3, 2'b11, 16'h0000);

        // Interrupts
        wr(2'd2, 2'b01, 16'h0001);
        bus_xfer(1'b1, 2'd2, 2'b11, 16'h0, 16'h0001);
        repeat (3) @(posedge clk); #1;
        chk("irq_rx_empty", {31'h0, bus_if.io_irq}, {31'h0, model_irq()});
        send_frame(8'h5A, 1'b1);
        repeat (10) @(posedge clk); #1;
        chk("irq_rx_full", {31'h0, bus_if.io_irq}, 32'h1);
        bus_xfer(1'b1, 2'd0, 2'b11, 16'h0, 16'h005A);
        void'(rx_q.pop_front());
        repeat (3) @(posedge clk); #1;
        chk("irq_rx_popped", {31'h0, bus_if.io_irq}, {31'h0, model_irq()});
        wr(2'd2, 2'b01, 16'h0002);
        repeat (3) @(posedge clk); #1;
        chk("irq_tx_idle", {31'h0, bus_if.io_irq}, {31'h0, model_irq()});
        wr(2'd2, 2'b01, 16'h0000);
        repeat (3) @(posedge clk); #1;
        chk("irq_off", {31'h0, bus_if.io_irq}, 32'h0);

        // Reset in the middle of a transmission
        wr(2'd0, 2'b01, 16'h0000);
        repeat (60) @(posedge clk);
        tx_track = 1'b0;
        stream.delete();
        @(negedge clk); #2;
        chk("txd_mid_frame", {31'h0, uart_txd}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_txd", {31'h0, uart_txd}, 32'h1);
        chk("reset_mid_ack", {31'h0, bus_if.io_acknowledge}, 32'h0);
        m_div = 16'd26;
        m_rx_ie = 1'b0;
        m_tx_ie = 1'b0;
        rx_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        bus_xfer(1'b1, 2'd3, 2'b11, 16'h0, 16'h001A);
        bus_xfer(1'b1, 2'd1, 2'b11, 16'h0, 16'h0006);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
